// File: rtl/instr_mem_arb_pkg.sv
// rtl/instr_mem_arb_pkg.sv - shared types and helpers for the instruction memory arbiter
// Contents: req_id_t requester ID, arb_state_e FSM states, NUM_REQ, other_id().
package instr_mem_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic {
        CORE0 = 1'b0,
        CORE1 = 1'b1
    } req_id_t;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    function automatic req_id_t other_id(input req_id_t id);
        return (id == CORE0) ? CORE1 : CORE0;
    endfunction

endpackage

// File: rtl/instr_mem_arb_id_fifo.sv
// rtl/instr_mem_arb_id_fifo.sv - requester-ID FIFO recording grant order for response routing
// Ports: clk, rst_n (async active-low), push/push_id, pop, head_id, full, empty, count.
// DEPTH must be a power of two; pointers wrap by masking with DEPTH-1.
module instr_mem_arb_id_fifo
    import instr_mem_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  req_id_t          push_id,
    input  logic             pop,
    output req_id_t          head_id,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);

    req_id_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head_id = mem[rd_ptr];

    // Overflow and underflow requests are ignored so the count never wraps.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr + 1'b1) & PTR_MASK;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr + 1'b1) & PTR_MASK;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Entries are only read when the count says they are valid, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

endmodule

// File: rtl/instr_mem_arbiter.sv
// rtl/instr_mem_arbiter.sv - round-robin arbiter sharing one instruction memory port between two cores
// Ports: clk_i, rst_ni (async active-low);
//   core0_instr_* / core1_instr_* : req/addr in, gnt/rvalid/rdata/err out (core fetch side);
//   instr_* : req/addr out, gnt/rvalid/rdata/err in (memory side).
// Optional: define INSTR_ARB_ASSERT_EN to compile in protocol assertions.
module instr_mem_arbiter
    import instr_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  core0_instr_req_i,
    output logic                  core0_instr_gnt_o,
    output logic                  core0_instr_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] core0_instr_addr_i,
    output logic [DATA_WIDTH-1:0] core0_instr_rdata_o,
    output logic                  core0_instr_err_o,

    input  logic                  core1_instr_req_i,
    output logic                  core1_instr_gnt_o,
    output logic                  core1_instr_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] core1_instr_addr_i,
    output logic [DATA_WIDTH-1:0] core1_instr_rdata_o,
    output logic                  core1_instr_err_o,

    output logic                  instr_req_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    input  logic [DATA_WIDTH-1:0] instr_rdata_i,
    input  logic                  instr_err_i
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [NUM_REQ-1:0]    core_req;
    logic [ADDR_WIDTH-1:0] core_addr [NUM_REQ];

    arb_state_e state, state_next;
    req_id_t    rr_ptr;
    req_id_t    lock_id, lock_id_next;
    req_id_t    winner;

    logic       mem_req;
    logic       handshake;
    logic       resp_pop;

    req_id_t    fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign core_req     = {core1_instr_req_i, core0_instr_req_i};
    assign core_addr[0] = core0_instr_addr_i;
    assign core_addr[1] = core1_instr_addr_i;

    // Winner selection and lock FSM. Once the memory has seen a request that
    // it did not grant, that request is held on the bus until granted so the
    // address cannot change under the memory.
    always_comb begin
        state_next   = state;
        lock_id_next = lock_id;
        winner       = rr_ptr;

        if (state == LOCKED) begin
            winner = lock_id;
        end else if (core_req[CORE0] && !core_req[CORE1]) begin
            winner = CORE0;
        end else if (core_req[CORE1] && !core_req[CORE0]) begin
            winner = CORE1;
        end else begin
            winner = rr_ptr;
        end

        // rst_ni gates the request so every output is quiet during reset.
        mem_req   = rst_ni && core_req[winner] && !fifo_full;
        handshake = mem_req && instr_gnt_i;

        case (state)
            ARB: begin
                if (mem_req && !instr_gnt_i) begin
                    state_next   = LOCKED;
                    lock_id_next = winner;
                end
            end
            LOCKED: begin
                if (instr_gnt_i) begin
                    state_next = ARB;
                end
            end
            default: state_next = ARB;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ARB;
            lock_id <= CORE0;
            rr_ptr  <= CORE0;
        end else begin
            state   <= state_next;
            lock_id <= lock_id_next;
            if (handshake) begin
                rr_ptr <= other_id(winner);
            end
        end
    end

    assign instr_req_o       = mem_req;
    assign instr_addr_o      = mem_req ? core_addr[winner] : '0;
    assign core0_instr_gnt_o = handshake && (winner == CORE0);
    assign core1_instr_gnt_o = handshake && (winner == CORE1);

    // A response arriving with nothing outstanding is dropped.
    assign resp_pop = instr_rvalid_i && !fifo_empty;

    instr_mem_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .push    (handshake),
        .push_id (winner),
        .pop     (resp_pop),
        .head_id (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign core0_instr_rvalid_o = resp_pop && (fifo_head == CORE0);
    assign core1_instr_rvalid_o = resp_pop && (fifo_head == CORE1);
    assign core0_instr_rdata_o  = rst_ni ? instr_rdata_i : '0;
    assign core1_instr_rdata_o  = rst_ni ? instr_rdata_i : '0;
    assign core0_instr_err_o    = core0_instr_rvalid_o && instr_err_i;
    assign core1_instr_err_o    = core1_instr_rvalid_o && instr_err_i;

`ifdef INSTR_ARB_ASSERT_EN
    a_no_rvalid_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_rvalid_i |-> !fifo_empty)
        else $error("instr_mem_arbiter: rvalid with no outstanding request");

    a_core0_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (core0_instr_req_i && !core0_instr_gnt_o) |=> $stable(core0_instr_addr_i))
        else $error("instr_mem_arbiter: core0 address changed before grant");

    a_core1_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (core1_instr_req_i && !core1_instr_gnt_o) |=> $stable(core1_instr_addr_i))
        else $error("instr_mem_arbiter: core1 address changed before grant");

    a_single_grant: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(core0_instr_gnt_o && core1_instr_gnt_o))
        else $error("instr_mem_arbiter: both cores granted");

    a_no_req_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(instr_req_o && (fifo_count == CNT_W'(MAX_OUTSTANDING))))
        else $error("instr_mem_arbiter: request issued with ID FIFO full");
`else
    logic unused_fifo_count;
    assign unused_fifo_count = ^fifo_count;
`endif

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// tb/tb_instr_mem_arbiter.sv - self-checking bench for instr_mem_arbiter
module tb_instr_mem_arbiter;

    localparam logic [31:0] A0 = 32'h0004_0080;
    localparam logic [31:0] A1 = 32'h0004_1000;
    localparam logic [31:0] J  = 32'hDEAD_BEEF;

    typedef struct {
        logic        rst_before;
        logic        c0_req;
        logic [31:0] c0_addr;
        logic        c1_req;
        logic [31:0] c1_addr;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_gnt0;
        logic        e_gnt1;
        logic        e_rv0;
        logic        e_rv1;
        logic        e_err0;
        logic        e_err1;
    } vec_t;

    logic        clk;
    logic        rst_ni;
    logic        c0_req, c1_req;
    logic [31:0] c0_addr, c1_addr;
    logic        c0_gnt, c1_gnt, c0_rv, c1_rv, c0_err, c1_err;
    logic [31:0] c0_rdata, c1_rdata;
    logic        m_req, m_gnt, m_rv, m_err;
    logic [31:0] m_addr, m_rdata;

    int checks = 0;
    int errors = 0;
    int sb_q[$];
    vec_t vecs[$];

    instr_mem_arbiter #(
        .ADDR_WIDTH      (32),
        .DATA_WIDTH      (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_ni),
        .core0_instr_req_i    (c0_req),
        .core0_instr_gnt_o    (c0_gnt),
        .core0_instr_rvalid_o (c0_rv),
        .core0_instr_addr_i   (c0_addr),
        .core0_instr_rdata_o  (c0_rdata),
        .core0_instr_err_o    (c0_err),
        .core1_instr_req_i    (c1_req),
        .core1_instr_gnt_o    (c1_gnt),
        .core1_instr_rvalid_o (c1_rv),
        .core1_instr_addr_i   (c1_addr),
        .core1_instr_rdata_o  (c1_rdata),
        .core1_instr_err_o    (c1_err),
        .instr_req_o          (m_req),
        .instr_gnt_i          (m_gnt),
        .instr_rvalid_i       (m_rv),
        .instr_addr_o         (m_addr),
        .instr_rdata_i        (m_rdata),
        .instr_err_i          (m_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rb, input logic r0, input logic [31:0] a0,
        input logic r1, input logic [31:0] a1, input logic g, input logic rv,
        input logic [31:0] rd, input logic er,
        input logic ereq, input logic [31:0] eaddr, input logic eg0, input logic eg1,
        input logic erv0, input logic erv1, input logic eer0, input logic eer1);
        vec_t v;
        v.rst_before = rb; v.c0_req = r0; v.c0_addr = a0; v.c1_req = r1; v.c1_addr = a1;
        v.gnt = g; v.rv = rv; v.rdata = rd; v.err = er;
        v.e_req = ereq; v.e_addr = eaddr; v.e_gnt0 = eg0; v.e_gnt1 = eg1;
        v.e_rv0 = erv0; v.e_rv1 = erv1; v.e_err0 = eer0; v.e_err1 = eer1;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        c0_req = 1'b0; c0_addr = J; c1_req = 1'b0; c1_addr = J;
        m_gnt = 1'b0; m_rv = 1'b0; m_rdata = '0; m_err = 1'b0;
    endtask

    task automatic chk_all_zero(input int idx);
        chk("rst_req_o",   idx, 32'(m_req),  32'd0);
        chk("rst_addr_o",  idx, m_addr,      32'd0);
        chk("rst_gnt0",    idx, 32'(c0_gnt), 32'd0);
        chk("rst_gnt1",    idx, 32'(c1_gnt), 32'd0);
        chk("rst_rv0",     idx, 32'(c0_rv),  32'd0);
        chk("rst_rv1",     idx, 32'(c1_rv),  32'd0);
        chk("rst_rdata0",  idx, c0_rdata,    32'd0);
        chk("rst_rdata1",  idx, c1_rdata,    32'd0);
        chk("rst_err0",    idx, 32'(c0_err), 32'd0);
        chk("rst_err1",    idx, 32'(c1_err), 32'd0);
    endtask

    task automatic do_reset(input int idx);
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk_all_zero(idx);
        @(negedge clk);
        rst_ni = 1'b1;
        sb_q.delete();
    endtask

    task automatic apply(input vec_t v, input int idx);
        int exp_id;
        if (v.rst_before) do_reset(idx);
        @(posedge clk);
        #1;
        c0_req = v.c0_req; c0_addr = v.c0_addr; c1_req = v.c1_req; c1_addr = v.c1_addr;
        m_gnt = v.gnt; m_rv = v.rv; m_rdata = v.rdata; m_err = v.err;
        @(negedge clk);
        chk("instr_req_o",  idx, 32'(m_req),  32'(v.e_req));
        chk("instr_addr_o", idx, m_addr,      v.e_addr);
        chk("core0_gnt",    idx, 32'(c0_gnt), 32'(v.e_gnt0));
        chk("core1_gnt",    idx, 32'(c1_gnt), 32'(v.e_gnt1));
        chk("core0_rvalid", idx, 32'(c0_rv),  32'(v.e_rv0));
        chk("core1_rvalid", idx, 32'(c1_rv),  32'(v.e_rv1));
        chk("core0_err",    idx, 32'(c0_err), 32'(v.e_err0));
        chk("core1_err",    idx, 32'(c1_err), 32'(v.e_err1));
        chk("core0_rdata",  idx, c0_rdata,    v.rdata);
        chk("core1_rdata",  idx, c1_rdata,    v.rdata);
        // Responses are popped from the grant-order scoreboard before this
        // cycle's grant is pushed, because a response always belongs to an
        // earlier grant.
        if (c0_rv || c1_rv) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_route row %0d: got response with no expected grant outstanding", idx);
            end else begin
                exp_id = sb_q.pop_front();
                chk("sb_route", idx, c1_rv ? 32'd1 : 32'd0, 32'(exp_id));
            end
        end
        if (v.e_gnt0) sb_q.push_back(0);
        if (v.e_gnt1) sb_q.push_back(1);
    endtask

    initial begin
        rst_ni = 1'b0;
        idle_inputs();

        // Single core0 fetch
        vecs.push_back(mk(1, 1,A0, 0,J,  1,0,32'h0,0,          1,A0, 1,0, 0,0, 0,0));
        vecs.push_back(mk(0, 0,J,  0,J,  0,1,32'h0000_0013,0,  0,0,  0,0, 1,0, 0,0));
        // Both request every cycle: alternating grants and responses
        vecs.push_back(mk(1, 1,A0, 1,A1, 1,0,32'h0,0,          1,A0, 1,0, 0,0, 0,0));
        vecs.push_back(mk(0, 1,A0, 1,A1, 1,1,32'h1111_0001,0,  1,A1, 0,1, 1,0, 0,0));
        vecs.push_back(mk(0, 1,A0, 1,A1, 1,1,32'h2222_0002,0,  1,A0, 1,0, 0,1, 0,0));
        vecs.push_back(mk(0, 1,A0, 1,A1, 1,1,32'h3333_0003,0,  1,A1, 0,1, 1,0, 0,0));
        vecs.push_back(mk(0, 0,J,  0,J,  0,1,32'h4444_0004,0,  0,0,  0,0, 0,1, 0,0));
        // Lock: core0 held on the bus while gnt withheld although pointer favours core1
        vecs.push_back(mk(1, 1,A0, 0,J,  1,0,32'h0,0,          1,A0, 1,0, 0,0, 0,0));
        vecs.push_back(mk(0, 1,A0, 0,J,  0,1,32'h5555_0005,0,  1,A0, 0,0, 1,0, 0,0));
        vecs.push_back(mk(0, 1,A0, 1,A1, 0,0,32'h0,0,          1,A0, 0,0, 0,0, 0,0));
        vecs.push_back(mk(0, 1,A0, 1,A1, 0,0,32'h0,0,          1,A0, 0,0, 0,0, 0,0));
        vecs.push_back(mk(0, 1,A0, 1,A1, 1,0,32'h0,0,          1,A0, 1,0, 0,0, 0,0));
        vecs.push_back(mk(0, 0,J,  1,A1, 1,1,32'h6666_0006,0,  1,A1, 0,1, 1,0, 0,0));
        vecs.push_back(mk(0, 0,J,  0,J,  0,1,32'h7777_0007,0,  0,0,  0,0, 0,1, 0,0));
        // Full FIFO blocks requests; a same-cycle pop does not unblock
        vecs.push_back(mk(1, 1,A0, 0,J,  1,0,32'h0,0,          1,A0, 1,0, 0,0, 0,0));
        vecs.push_back(mk(0, 1,A0, 0,J,  1,0,32'h0,0,          1,A0, 1,0, 0,0, 0,0));
        vecs.push_back(mk(0, 1,A0, 1,A1, 1,0,32'h0,0,          0,0,  0,0, 0,0, 0,0));
        vecs.push_back(mk(0, 1,A0, 1,A1, 1,1,32'h8888_0008,0,  0,0,  0,0, 1,0, 0,0));
        vecs.push_back(mk(0, 1,A0, 1,A1, 1,0,32'h0,0,          1,A1, 0,1, 0,0, 0,0));
        vecs.push_back(mk(0, 1,A0, 0,J,  0,1,32'h9999_0009,0,  0,0,  0,0, 1,0, 0,0));
        vecs.push_back(mk(0, 1,A0, 0,J,  1,1,32'hAAAA_000A,0,  1,A0, 1,0, 0,1, 0,0));
        vecs.push_back(mk(0, 0,J,  0,J,  0,1,32'hBBBB_000B,0,  0,0,  0,0, 1,0, 0,0));
        vecs.push_back(mk(0, 0,J,  0,J,  0,1,32'hCCCC_000C,1,  0,0,  0,0, 0,0, 0,0));
        // Error routed only to the owning core
        vecs.push_back(mk(1, 0,J,  1,A1, 1,0,32'h0,0,          1,A1, 0,1, 0,0, 0,0));
        vecs.push_back(mk(0, 1,A0, 0,J,  1,0,32'h0,0,          1,A0, 1,0, 0,0, 0,0));
        vecs.push_back(mk(0, 0,J,  0,J,  0,1,32'hDDDD_000D,1,  0,0,  0,0, 0,1, 0,1));
        vecs.push_back(mk(0, 0,J,  0,J,  0,1,32'hEEEE_000E,0,  0,0,  0,0, 1,0, 0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Reset with two outstanding, busy inputs during reset, stale response afterwards
        apply(mk(1, 1,A0, 0,J,  1,0,32'h0,0,                   1,A0, 1,0, 0,0, 0,0), 100);
        apply(mk(0, 0,J,  1,A1, 1,0,32'h0,0,                   1,A1, 0,1, 0,0, 0,0), 101);
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        c0_req = 1'b1; c0_addr = A0; c1_req = 1'b1; c1_addr = A1;
        m_gnt = 1'b1; m_rv = 1'b1; m_rdata = 32'hABCD_1234; m_err = 1'b1;
        @(negedge clk);
        chk_all_zero(102);
        @(posedge clk);
        @(negedge clk);
        chk_all_zero(103);
        idle_inputs();
        rst_ni = 1'b1;
        sb_q.delete();
        apply(mk(0, 0,J,  0,J,  0,1,32'h5A5A_5A5A,0,           0,0,  0,0, 0,0, 0,0), 104);
        apply(mk(0, 1,A0, 1,A1, 1,0,32'h0,0,                   1,A0, 1,0, 0,0, 0,0), 105);
        apply(mk(0, 0,J,  0,J,  0,1,32'h0000_0013,0,           0,0,  0,0, 1,0, 0,0), 106);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_mem_arbiter.md
Name: instr_mem_arbiter

Overview:
Shares one instruction-memory port between two core fetch ports (core0, core1). Uses the OBI-style req/gnt/rvalid handshake on every side. Sits between the two cores' fetch interfaces and the single upstream instr_mem_decoder/ROM port. Round-robin arbitration on request. In-order response routing via a small requester-ID FIFO.

Parameters:
ADDR_WIDTH, 32, address width on all ports
DATA_WIDTH, 32, instruction data width
MAX_OUTSTANDING, 2, max granted-but-unanswered transactions (ID FIFO depth, power of 2, >=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
core0_instr_req_i  in  1  core0 request
core0_instr_gnt_o  out  1  core0 grant
core0_instr_rvalid_o  out  1  core0 response valid
core0_instr_addr_i  in  ADDR_WIDTH  core0 fetch address
core0_instr_rdata_o  out  DATA_WIDTH  core0 read data
core0_instr_err_o  out  1  core0 bus error
core1_instr_*  (same six signals as core0, same directions and widths)  core1 fetch port
instr_req_o  out  1  memory request
instr_gnt_i  in  1  memory grant
instr_rvalid_i  in  1  memory response valid
instr_addr_o  out  ADDR_WIDTH  memory address
instr_rdata_i  in  DATA_WIDTH  memory read data
instr_err_i  in  1  memory bus error

Behaviour:
- Reset (async assert, sync deassert assumed upstream): all req/gnt/rvalid/err outputs 0; addr/rdata outputs 0; priority pointer = core0; FIFO empty; lock cleared.
- Protocol: a requester holds req and addr stable until gnt. gnt is combinational in the same cycle. rvalid comes >=1 cycle after gnt, in grant order.
- Arbitration FSM (2 states):
  - ARB: winner = requesting core. If both request, winner = pointer core.
  - LOCKED: entered when instr_req_o=1 and instr_gnt_i=0. Winner is frozen to the latched ID regardless of the other core. Exit to ARB on instr_gnt_i=1.
- instr_req_o = winner req AND NOT fifo_full. instr_addr_o = winner addr, or 0 when no request.
- coreN_instr_gnt_o = instr_gnt_i AND instr_req_o AND (winner==N). The loser sees gnt=0.
- Handshake (instr_req_o & instr_gnt_i):
  - push winner ID into FIFO.
  - pointer <= other core.
- Response (instr_rvalid_i):
  - pop FIFO head.
  - coreN_instr_rvalid_o = instr_rvalid_i & (head==N); the other core gets rvalid=0.
  - rdata/err forwarded to both ports; err gated by that port's rvalid.
  - Zero added latency (combinational).
- Simultaneous push+pop: count unchanged, legal even at count==MAX_OUTSTANDING-1.
- Full: when count==MAX_OUTSTANDING, requests are blocked (instr_req_o=0). A pop in the same cycle does not unblock; the request proceeds next cycle.
- rvalid with empty FIFO: protocol violation. Response dropped (no core rvalid), count stays 0.
- Reset mid-transaction: FIFO and lock discarded; late memory rvalids after reset are dropped per the empty rule.

Optional Feature:
INSTR_ARB_ASSERT_EN
- Defined: SVA assertions are compiled in:
  - no rvalid while FIFO empty;
  - coreN addr stable while req & !gnt;
  - never both core gnts high;
  - instr_req_o never high while full.
  - Failures report via $error.
- Undefined: no assertions; RTL is functionally identical.

Decomposition:
- Package instr_mem_arb_pkg:
  - typedef req_id_t (1-bit enum CORE0=0, CORE1=1);
  - NUM_REQ=2;
  - helper function other_id().
- Sub-module instr_mem_arb_id_fifo:
  - parameterised-depth FIFO of req_id_t with push/pop/full/empty/count;
  - pointer wrap by depth mask.
- Arbiter FSM, pointer and lock stay in the top module.

Test Plan:
1. Core0 only, req=1, addr=0x00040080, memory gnt immediate, rvalid next cycle with rdata=0x00000013 -> core0 gnt in cycle 0, core0 rvalid/rdata=0x00000013 in cycle 1; core1 rvalid stays 0.
2. Both request every cycle, addrs 0x00040080/0x00041000, gnt always 1 -> grants alternate core0, core1, core0…; rvalids routed in the same alternating order.
3. Both request, memory withholds gnt 3 cycles -> instr_addr_o stays 0x00040080 (core0) all 3 cycles despite core1 req; core0 granted on cycle 4; core1 granted next.
4. MAX_OUTSTANDING=2, gnt=1, rvalid withheld -> after 2 grants instr_req_o=0. rvalid in cycle k -> instr_req_o=1 in cycle k+1, not k.
5. rvalid with err=1 for core1's transaction -> core1_instr_err_o=1 with rvalid; core0_instr_err_o=0.
6. rst_ni pulled low with 2 outstanding, then released; memory then asserts 1 stale rvalid -> all outputs 0 during reset; stale rvalid dropped; next core0 request granted normally.
